mpif_sync_fifo_ctrl: RTL and testbench

Single-clock FIFO pointer/status controller that generalises the dual-clock tx/rx FIFO controller.
- Supports non-power-of-2 depth, an explicit occupancy count and programmable almost-full/almost-empty thresholds.
- Detects overflow/underflow with sticky flags.
- Drives the address ports of an external dual-port RAM inside the MAC/host-interface datapath, where both sides share one clock.

---
 rtl/mpif_fifo_pkg.sv | 30 +++
 rtl/mpif_sync_fifo_ctrl_if.sv | 51 +++++
 rtl/mpif_fifo_ptr_wrap.sv | 39 +++
 rtl/mpif_sync_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_mpif_sync_fifo_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mpif_fifo_pkg.sv
// Shared definitions for the single-clock FIFO pointer/status controller:
// pointer wrap helper, level width helper, reset values and level update ops.
package mpif_fifo_pkg;

    localparam int unsigned ADDRWIDTH_DEFAULT = 4;
    localparam int unsigned DEPTH_DEFAULT     = 16;

    // Level needs one bit more than the pointers to represent 0..DEPTH.
    localparam int unsigned LEVEL_EXTRA_BITS  = 1;

    localparam int unsigned PTR_RST   = 0;
    localparam int unsigned LEVEL_RST = 0;
    localparam logic        FLAG_RST  = 1'b0;

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_INC,
        LVL_DEC
    } lvl_op_e;

    function automatic int unsigned levelWidth(input int unsigned addrWidth);
        return addrWidth + LEVEL_EXTRA_BITS;
    endfunction

    // Binary increment that wraps at DEPTH-1 so non-power-of-2 depths work.
    function automatic int unsigned nextPtr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/mpif_sync_fifo_ctrl_if.sv
// Request/status bundle of the FIFO controller.
// Optional MPIF_FIFO_PEAK_LEVEL_EN adds peakClear / fifoPeakLevel.
interface mpif_sync_fifo_ctrl_if
    import mpif_fifo_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEFAULT
);
    localparam int unsigned LW = levelWidth(ADDRWIDTH);

    logic                 flush;
    logic                 fifoWrite;
    logic                 fifoRead;
    logic [LW-1:0]        almostFullThr;
    logic [LW-1:0]        almostEmptyThr;
    logic                 errClear;
    logic [ADDRWIDTH-1:0] fifoWrPtr;
    logic [ADDRWIDTH-1:0] fifoRdPtr;
    logic [LW-1:0]        fifoLevel;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 fifoAlmostFull;
    logic                 fifoAlmostEmpty;
    logic                 fifoPtrsNull;
    logic                 fifoOverflow;
    logic                 fifoUnderflow;
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
    logic                 peakClear;
    logic [LW-1:0]        fifoPeakLevel;
`endif

    modport master (
        output flush, fifoWrite, fifoRead, almostFullThr, almostEmptyThr, errClear,
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        output peakClear,
        input  fifoPeakLevel,
`endif
        input  fifoWrPtr, fifoRdPtr, fifoLevel, fifoFull, fifoEmpty,
               fifoAlmostFull, fifoAlmostEmpty, fifoPtrsNull, fifoOverflow, fifoUnderflow
    );

    modport slave (
        input  flush, fifoWrite, fifoRead, almostFullThr, almostEmptyThr, errClear,
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        input  peakClear,
        output fifoPeakLevel,
`endif
        output fifoWrPtr, fifoRdPtr, fifoLevel, fifoFull, fifoEmpty,
               fifoAlmostFull, fifoAlmostEmpty, fifoPtrsNull, fifoOverflow, fifoUnderflow
    );

endinterface

// File: rtl/mpif_fifo_ptr_wrap.sv
// Single FIFO pointer register: advances on enable, wraps at DEPTH-1,
// synchronous flush to zero takes priority.
module mpif_fifo_ptr_wrap
    import mpif_fifo_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 hardReset_n,
    input  logic                 en_i,
    input  logic                 flush_i,
    output logic [ADDRWIDTH-1:0] ptr_o
);

    logic [ADDRWIDTH-1:0] ptr_q, ptr_d;

    // Next pointer: flush first, then wrap-aware increment.
    always_comb begin
        ptr_d = ptr_q;
        if (flush_i) begin
            ptr_d = ADDRWIDTH'(PTR_RST);
        end else if (en_i) begin
            ptr_d = ADDRWIDTH'(nextPtr(32'(ptr_q), DEPTH));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) begin
            ptr_q <= ADDRWIDTH'(PTR_RST);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mpif_sync_fifo_ctrl.sv
// Single-clock FIFO pointer/status controller for an external dual-port RAM.
// Optional MPIF_FIFO_PEAK_LEVEL_EN adds a peak-occupancy register.
module mpif_sync_fifo_ctrl
    import mpif_fifo_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = ADDRWIDTH_DEFAULT,
    parameter int unsigned DEPTH     = DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 hardReset_n,
    mpif_sync_fifo_ctrl_if.slave bus
);

    localparam int unsigned LW = levelWidth(ADDRWIDTH);

    logic [LW-1:0]        level_q, level_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 fullFlag, emptyFlag;
    logic                 rdAcc, wrAcc;
    lvl_op_e              levelOp;
    logic [ADDRWIDTH-1:0] wrPtr, rdPtr;

    assign fullFlag  = (level_q == LW'(DEPTH));
    assign emptyFlag = (level_q == '0);

    // A read frees a slot in the same cycle, so full+read+write accepts both.
    assign rdAcc = bus.fifoRead & ~emptyFlag;
    assign wrAcc = bus.fifoWrite & (~fullFlag | rdAcc);

    mpif_fifo_ptr_wrap #(.ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) u_wr_ptr (
        .clk         (clk),
        .hardReset_n (hardReset_n),
        .en_i        (wrAcc),
        .flush_i     (bus.flush),
        .ptr_o       (wrPtr)
    );

    mpif_fifo_ptr_wrap #(.ADDRWIDTH(ADDRWIDTH), .DEPTH(DEPTH)) u_rd_ptr (
        .clk         (clk),
        .hardReset_n (hardReset_n),
        .en_i        (rdAcc),
        .flush_i     (bus.flush),
        .ptr_o       (rdPtr)
    );

    // Classify the accepted access pair into a level operation.
    always_comb begin
        levelOp = LVL_HOLD;
        if (wrAcc && !rdAcc) begin
            levelOp = LVL_INC;
        end else if (rdAcc && !wrAcc) begin
            levelOp = LVL_DEC;
        end
    end

    // Next level and sticky error flags; flush discards accesses but not errors.
    always_comb begin
        level_d = level_q;
        if (bus.flush) begin
            level_d = LW'(LEVEL_RST);
        end else begin
            case (levelOp)
                LVL_INC: level_d = level_q + LW'(1);
                LVL_DEC: level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
        ovf_d = (bus.fifoWrite & ~wrAcc & ~bus.flush) | (ovf_q & ~bus.errClear);
        unf_d = (bus.fifoRead  & ~rdAcc & ~bus.flush) | (unf_q & ~bus.errClear);
    end

    // Level and sticky flag registers.
    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) begin
            level_q <= LW'(LEVEL_RST);
            ovf_q   <= FLAG_RST;
            unf_q   <= FLAG_RST;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef MPIF_FIFO_PEAK_LEVEL_EN
    logic [LW-1:0] peak_q, peak_d;

    // Track the running maximum of the registered level; clear reloads it.
    always_comb begin
        peak_d = peak_q;
        if (bus.peakClear) begin
            peak_d = level_q;
        end else if (level_q > peak_q) begin
            peak_d = level_q;
        end
    end

    // Peak register, untouched by flush.
    always_ff @(posedge clk or negedge hardReset_n) begin
        if (!hardReset_n) begin
            peak_q <= LW'(LEVEL_RST);
        end else begin
            peak_q <= peak_d;
        end
    end

    assign bus.fifoPeakLevel = peak_q;
`endif

    assign bus.fifoWrPtr       = wrPtr;
    assign bus.fifoRdPtr       = rdPtr;
    assign bus.fifoLevel       = level_q;
    assign bus.fifoFull        = fullFlag;
    assign bus.fifoEmpty       = emptyFlag;
    assign bus.fifoAlmostFull  = (level_q >= bus.almostFullThr);
    assign bus.fifoAlmostEmpty = (level_q <= bus.almostEmptyThr);
    assign bus.fifoPtrsNull    = (wrPtr == '0) && (rdPtr == '0) && emptyFlag;
    assign bus.fifoOverflow    = ovf_q;
    assign bus.fifoUnderflow   = unf_q;

endmodule

// File: tb/tb_mpif_sync_fifo_ctrl.sv
// Bench for mpif_sync_fifo_ctrl: a DEPTH=16 and a DEPTH=10 instance driven in
// lockstep and compared against an occupancy/write-count reference model.
// Define MPIF_FIFO_PEAK_LEVEL_EN to also exercise the peak-level register.
module tb_mpif_sync_fifo_ctrl;

    logic clk = 1'b0;
    logic hardReset_n;

    always #5 clk = ~clk;

    mpif_sync_fifo_ctrl_if #(.ADDRWIDTH(4)) if0 ();
    mpif_sync_fifo_ctrl_if #(.ADDRWIDTH(4)) if1 ();

    mpif_sync_fifo_ctrl #(.ADDRWIDTH(4), .DEPTH(16)) u_dut0 (
        .clk         (clk),
        .hardReset_n (hardReset_n),
        .bus         (if0)
    );

    mpif_sync_fifo_ctrl #(.ADDRWIDTH(4), .DEPTH(10)) u_dut1 (
        .clk         (clk),
        .hardReset_n (hardReset_n),
        .bus         (if1)
    );

    int unsigned nChecks = 0;
    int unsigned nErrors = 0;

    // Reference model: occupancy, write address, sticky flags, peak.
    int unsigned D     [2] = '{16, 10};
    int unsigned mLvl  [2];
    int unsigned mWp   [2];
    int unsigned mOvf  [2];
    int unsigned mUnf  [2];
    int unsigned mPeak [2];
    int unsigned mAf   [2];
    int unsigned mAe   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_thr(input int unsigned i, input int unsigned af, input int unsigned ae);
        mAf[i] = af;
        mAe[i] = ae;
        if (i == 0) begin
            if0.almostFullThr  = 5'(af);
            if0.almostEmptyThr = 5'(ae);
        end else begin
            if1.almostFullThr  = 5'(af);
            if1.almostEmptyThr = 5'(ae);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mLvl[i] = 0; mWp[i] = 0; mOvf[i] = 0; mUnf[i] = 0; mPeak[i] = 0;
        end
    endtask

    task automatic check_inst(input string tag, input int unsigned i,
                              input logic [31:0] lvl, input logic [31:0] wp, input logic [31:0] rp,
                              input logic full, input logic empty, input logic af, input logic ae,
                              input logic pnull, input logic ovf, input logic unf,
                              input logic [31:0] peak);
        int unsigned rpExp;
        // Read address trails the write address by the occupancy, modulo DEPTH.
        rpExp = (mWp[i] + D[i] - mLvl[i]) % D[i];
        chk({tag, "_level"}, lvl, mLvl[i]);
        chk({tag, "_wrptr"}, wp, mWp[i]);
        chk({tag, "_rdptr"}, rp, rpExp);
        chk({tag, "_full"},  32'(full),  32'(mLvl[i] == D[i]));
        chk({tag, "_empty"}, 32'(empty), 32'(mLvl[i] == 0));
        chk({tag, "_afull"}, 32'(af),    32'(mLvl[i] >= mAf[i]));
        chk({tag, "_aempty"},32'(ae),    32'(mLvl[i] <= mAe[i]));
        chk({tag, "_null"},  32'(pnull), 32'(mLvl[i] == 0 && mWp[i] == 0));
        chk({tag, "_ovf"},   32'(ovf),   mOvf[i]);
        chk({tag, "_unf"},   32'(unf),   mUnf[i]);
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        chk({tag, "_peak"},  peak,       mPeak[i]);
`else
        if (peak != 32'd0) chk({tag, "_peak_unused"}, peak, 32'd0);
`endif
    endtask

    task automatic check_all(input string tag);
        logic [31:0] pk0, pk1;
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        pk0 = 32'(if0.fifoPeakLevel);
        pk1 = 32'(if1.fifoPeakLevel);
`else
        pk0 = 32'd0;
        pk1 = 32'd0;
`endif
        check_inst({tag, "_d16"}, 0, 32'(if0.fifoLevel), 32'(if0.fifoWrPtr), 32'(if0.fifoRdPtr),
                   if0.fifoFull, if0.fifoEmpty, if0.fifoAlmostFull, if0.fifoAlmostEmpty,
                   if0.fifoPtrsNull, if0.fifoOverflow, if0.fifoUnderflow, pk0);
        check_inst({tag, "_d10"}, 1, 32'(if1.fifoLevel), 32'(if1.fifoWrPtr), 32'(if1.fifoRdPtr),
                   if1.fifoFull, if1.fifoEmpty, if1.fifoAlmostFull, if1.fifoAlmostEmpty,
                   if1.fifoPtrsNull, if1.fifoOverflow, if1.fifoUnderflow, pk1);
    endtask

    // One clock of stimulus: drive, advance the model, clock, check both instances.
    task automatic step(input string tag, input logic w0, input logic r0, input logic w1, input logic r1,
                        input logic fl0, input logic fl1, input logic ec, input logic pc);
        logic w [2];
        logic r [2];
        logic fl [2];
        int unsigned oldLvl;
        logic rA, wA;
        w[0] = w0; w[1] = w1; r[0] = r0; r[1] = r1; fl[0] = fl0; fl[1] = fl1;
        if0.fifoWrite = w0; if0.fifoRead = r0; if0.flush = fl0; if0.errClear = ec;
        if1.fifoWrite = w1; if1.fifoRead = r1; if1.flush = fl1; if1.errClear = ec;
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        if0.peakClear = pc;
        if1.peakClear = pc;
`endif
        for (int i = 0; i < 2; i++) begin
            oldLvl = mLvl[i];
            rA = r[i] && (oldLvl != 0);
            wA = w[i] && ((oldLvl != D[i]) || rA);
            mOvf[i] = ((w[i] && !wA && !fl[i]) || (mOvf[i] != 0 && !ec)) ? 1 : 0;
            mUnf[i] = ((r[i] && !rA && !fl[i]) || (mUnf[i] != 0 && !ec)) ? 1 : 0;
            if (pc) mPeak[i] = oldLvl;
            else if (oldLvl > mPeak[i]) mPeak[i] = oldLvl;
            if (fl[i]) begin
                mLvl[i] = 0;
                mWp[i]  = 0;
            end else begin
                mLvl[i] = oldLvl + (wA ? 1 : 0) - (rA ? 1 : 0);
                if (wA) mWp[i] = (mWp[i] + 1) % D[i];
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        hardReset_n = 1'b0;
        if0.fifoWrite = 1'b0; if0.fifoRead = 1'b0; if0.flush = 1'b0; if0.errClear = 1'b0;
        if1.fifoWrite = 1'b0; if1.fifoRead = 1'b0; if1.flush = 1'b0; if1.errClear = 1'b0;
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        if0.peakClear = 1'b0;
        if1.peakClear = 1'b0;
`endif
        set_thr(0, 12, 2);
        set_thr(1, 0, 3);
        model_reset();

        // Reset state, including almost-full forced by a zero threshold on d10.
        #12;
        check_all("reset");
        chk("reset_af_thr0", 32'(if1.fifoAlmostFull), 32'd1);
        #5;
        hardReset_n = 1'b1;
        set_thr(1, 8, 3);

        // Fill d16: level 1..16, almost-full from 12, full at 16, write pointer wraps.
        for (int k = 0; k < 16; k++) step("fill", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill_level16", 32'(if0.fifoLevel), 32'd16);
        chk("fill_wrap",    32'(if0.fifoWrPtr), 32'd0);

        // Full + write only, then full + read + write, then clear the error.
        step("full_wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_wr_ovf", 32'(if0.fifoOverflow), 32'd1);
        step("full_rw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_rw_rdptr", 32'(if0.fifoRdPtr), 32'd1);
        step("errclr",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("errclr_ovf", 32'(if0.fifoOverflow), 32'd0);

        // Flush, then empty + read + write.
        step("flush0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("empty_rw", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("empty_rw_unf",   32'(if0.fifoUnderflow), 32'd1);
        chk("empty_rw_rdptr", 32'(if0.fifoRdPtr), 32'd0);

        // Level 7 then flush with a concurrent write: nothing flagged, stickies kept.
        for (int k = 0; k < 6; k++) step("to7", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("flush_wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("flush_wr_null", 32'(if0.fifoPtrsNull), 32'd1);

        // d10: 25 write/read pairs (first read underflows), then fill to full.
        for (int k = 0; k < 25; k++) step("pairs10", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("drain10", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 11; k++) step("fill10", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("fill10_level", 32'(if1.fifoLevel), 32'd10);

        // Peak tracking: write 9, read 5, then clear to the current level.
        step("pk_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step("pk_clr0",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) step("pk_wr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step("pk_rd", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        chk("peak9", 32'(if0.fifoPeakLevel), 32'd9);
`endif
        step("pk_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef MPIF_FIFO_PEAK_LEVEL_EN
        chk("peak_clr4", 32'(if0.fifoPeakLevel), 32'd4);
`endif

        // Randomized traffic with a fill-biased then drain-biased phase.
        for (int k = 0; k < 600; k++) begin
            logic w0, r0, w1, r1, fl0, fl1, ec, pc;
            bit fillPhase;
            fillPhase = ((k / 100) % 2) == 0;
            w0 = fillPhase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r0 = fillPhase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            w1 = fillPhase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r1 = fillPhase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl0 = ($urandom_range(0, 63) == 0);
            fl1 = ($urandom_range(0, 63) == 0);
            ec  = ($urandom_range(0, 15) == 0);
            pc  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 49) == 0) set_thr(0, $urandom_range(0, 31), $urandom_range(0, 31));
            if ($urandom_range(0, 49) == 0) set_thr(1, $urandom_range(0, 31), $urandom_range(0, 31));
            step("rand", w0, r0, w1, r1, fl0, fl1, ec, pc);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
